// File: rtl/pixel_frame_buffer.sv
// pixel_frame_buffer
//
// Double-buffered pixel store between the eye/face pixel generators and the
// LED panel scanout. The pixel stream writes the back bank. Scanout reads the
// front bank with a fixed 2-cycle latency. Banks swap only on a scanout
// frame_start_in pulse, and only after the back bank has received a write to
// its last address.
//
// Ports
//   clk_in               : single clock
//   rst_in               : synchronous reset, active low
//   pixel_address_in     : write address (row*NUM_PIXELS + col)
//   pixel_data_in        : write data
//   pixel_valid_in       : write strobe
//   frame_ready_out      : back bank accepting writes
//   frame_start_in       : scanout frame boundary pulse
//   read_address_in      : scanout read address
//   read_request_in      : read strobe
//   read_data_out        : front-bank data, 2 cycles after the request
//   read_data_valid_out  : qualifies read_data_out
//   display_bank_out     : index of the current front bank
//   swap_done_out        : one-cycle pulse in the cycle after a swap
//   write_overflow_out   : sticky, set when a write is dropped while pending

module pixel_frame_buffer #(
  parameter int unsigned NUM_BLOCK_ROWS  = 16,
  parameter int unsigned NUM_PIXELS      = 128,
  parameter int unsigned LOG_POWER_MOD   = 4,
  parameter int unsigned TOTAL_ADDRESSES = NUM_BLOCK_ROWS * NUM_PIXELS,
  parameter int unsigned ADDRESS_SIZE    = $clog2(TOTAL_ADDRESSES),
  parameter int unsigned PIXEL_SIZE      = 3 * LOG_POWER_MOD
) (
  input  logic                    clk_in,
  input  logic                    rst_in,
  input  logic [ADDRESS_SIZE-1:0] pixel_address_in,
  input  logic [PIXEL_SIZE-1:0]   pixel_data_in,
  input  logic                    pixel_valid_in,
  output logic                    frame_ready_out,
  input  logic                    frame_start_in,
  input  logic [ADDRESS_SIZE-1:0] read_address_in,
  input  logic                    read_request_in,
  output logic [PIXEL_SIZE-1:0]   read_data_out,
  output logic                    read_data_valid_out,
  output logic                    display_bank_out,
  output logic                    swap_done_out,
  output logic                    write_overflow_out
);

  localparam logic [0:0] FILLING = 1'b0;
  localparam logic [0:0] PENDING = 1'b1;

  logic [0:0] state_q, state_d;
  logic       display_bank_q, display_bank_d;
  logic       overflow_q, overflow_d;
  logic       swap_done_q;

  logic wr_in_range;
  logic rd_in_range;
  logic wr_last;
  logic wr_en;
  logic swap_take;

  // Zero-extend before comparing so a power-of-two depth does not wrap.
  assign wr_in_range = 32'(pixel_address_in) < TOTAL_ADDRESSES;
  assign rd_in_range = 32'(read_address_in) < TOTAL_ADDRESSES;
  assign wr_last     = pixel_address_in == ADDRESS_SIZE'(TOTAL_ADDRESSES - 1);
  assign wr_en       = (state_q == FILLING) && pixel_valid_in && wr_in_range;
  assign swap_take   = (state_q == PENDING) && frame_start_in;

  always_comb begin
    state_d        = state_q;
    display_bank_d = display_bank_q;
    overflow_d     = overflow_q;
    case (state_q)
      FILLING: begin
        // frame_start_in is ignored here, even in the last-write cycle.
        if (wr_en && wr_last) state_d = PENDING;
      end
      PENDING: begin
        if (pixel_valid_in && wr_in_range) overflow_d = 1'b1;
        if (frame_start_in) begin
          state_d        = FILLING;
          display_bank_d = ~display_bank_q;
        end
      end
      default: state_d = FILLING;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q        <= FILLING;
      display_bank_q <= 1'b0;
      overflow_q     <= 1'b0;
      swap_done_q    <= 1'b0;
    end else begin
      state_q        <= state_d;
      display_bank_q <= display_bank_d;
      overflow_q     <= overflow_d;
      swap_done_q    <= swap_take;
    end
  end

  // Pixel storage: no reset so each bank maps onto block RAM.
  logic [PIXEL_SIZE-1:0] bank0 [TOTAL_ADDRESSES];
  logic [PIXEL_SIZE-1:0] bank1 [TOTAL_ADDRESSES];

  // The back bank is the one not on display.
  always_ff @(posedge clk_in) begin
    if (wr_en && display_bank_q) bank0[pixel_address_in] <= pixel_data_in;
  end

  always_ff @(posedge clk_in) begin
    if (wr_en && !display_bank_q) bank1[pixel_address_in] <= pixel_data_in;
  end

  // Read stage 1: capture request and the bank on display at request time,
  // so a read issued alongside the swapping frame_start_in sees the old bank.
  logic                    rd_valid_q;
  logic [ADDRESS_SIZE-1:0] rd_addr_q;
  logic                    rd_bank_q;
  logic                    rd_in_range_q;

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= read_request_in;
    end
  end

  always_ff @(posedge clk_in) begin
    rd_addr_q     <= read_address_in;
    rd_bank_q     <= display_bank_q;
    rd_in_range_q <= rd_in_range;
  end

  // Read stage 2: memory read into the output register.
  logic [PIXEL_SIZE-1:0] rd_data;
  logic [PIXEL_SIZE-1:0] read_data_q;
  logic                  read_valid_q;

  always_comb begin
    rd_data = '0;
    if (rd_in_range_q) rd_data = rd_bank_q ? bank1[rd_addr_q] : bank0[rd_addr_q];
  end

  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      read_data_q  <= '0;
      read_valid_q <= 1'b0;
    end else begin
      read_valid_q <= rd_valid_q;
      if (rd_valid_q) read_data_q <= rd_data;
    end
  end

  assign frame_ready_out     = (state_q == FILLING);
  assign read_data_out       = read_data_q;
  assign read_data_valid_out = read_valid_q;
  assign display_bank_out    = display_bank_q;
  assign swap_done_out       = swap_done_q;
  assign write_overflow_out  = overflow_q;

endmodule
